// File: rtl/binary_encoder_seq.sv
// Sequential multi-hot to binary index encoder: emits the index of every set bit, lowest first.
// Optional pop_count output enabled by defining BIN_ENC_POPCNT_EN.
module binary_encoder_seq #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] encoder_in,
    output logic             in_ready,
    output logic [IDX_W-1:0] binary_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             last
`ifdef BIN_ENC_POPCNT_EN
    ,
    output logic [IDX_W:0]   pop_count
`endif
);

    localparam int CW = IDX_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic [WIDTH-1:0]   nxt_vec;
    logic               upd;

    function automatic logic [IDX_W-1:0] low_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic one_left(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    // Next-state: load a vector in IDLE, retire the lowest pending bit on each handshake
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        last_d    = last_q;
        nxt_vec   = '0;
        upd       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && encoder_in != '0) begin
                    nxt_vec = encoder_in;
                    upd     = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    nxt_vec = pending_q & (pending_q - WIDTH'(1));
                    upd     = 1'b1;
                    if (last_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (upd) begin
            pending_d = nxt_vec;
            idx_d     = low_idx(nxt_vec);
            last_d    = one_left(nxt_vec);
        end
    end

    // State, pending vector and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
        end
    end

`ifdef BIN_ENC_POPCNT_EN
    logic [IDX_W:0] pop_q, pop_d;

    // Popcount of the incoming vector, captured only when it is accepted
    always_comb begin
        pop_d = pop_q;
        if (state_q == IDLE && enable && encoder_in != '0) begin
            pop_d = '0;
            for (int i = 0; i < WIDTH; i++) begin
                pop_d = pop_d + CW'(encoder_in[i]);
            end
        end
    end

    // Hold the count until the next load or reset
    always_ff @(posedge clk) begin
        if (reset) pop_q <= '0;
        else       pop_q <= pop_d;
    end

    assign pop_count = pop_q;
`endif

    assign in_ready   = (state_q == IDLE) & ~reset;
    assign out_valid  = (state_q == EMIT);
    assign binary_out = idx_q;
    assign last       = last_q;

endmodule

// File: tb/tb_binary_encoder_seq.sv
// Self-checking bench for binary_encoder_seq: queue-based model plus directed literals.
// Define BIN_ENC_POPCNT_EN to also check pop_count.
module tb_binary_encoder_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] encoder_in;
    logic        in_ready;
    logic [3:0]  binary_out;
    logic        out_valid;
    logic        out_ready;
    logic        last;
`ifdef BIN_ENC_POPCNT_EN
    logic [4:0]  pop_count;
`endif

    int errs   = 0;
    int checks = 0;
    bit done   = 0;

    logic [3:0] mq[$];
    int         model_pc = 0;

    binary_encoder_seq #(.WIDTH(16), .IDX_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .encoder_in (encoder_in),
        .in_ready   (in_ready),
        .binary_out (binary_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .last       (last)
`ifdef BIN_ENC_POPCNT_EN
        ,
        .pop_count  (pop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: a queue of indices still to be emitted
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            model_pc = 0;
        end else if (mq.size() != 0) begin
            if (out_ready) void'(mq.pop_front());
        end else if (enable && encoder_in != 16'h0) begin
            model_pc = 0;
            for (int b = 0; b < 16; b++) begin
                if (encoder_in[b]) begin
                    mq.push_back(4'(b));
                    model_pc++;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        @(posedge clk);
        while (!done) begin
            @(negedge clk);
            if (!done) begin
                chk("m_valid", out_valid, mq.size() != 0);
                chk("m_in_ready", in_ready, (mq.size() == 0) && !reset);
                if (mq.size() != 0) begin
                    chk("m_index", binary_out, mq[0]);
                    chk("m_last", last, mq.size() == 1);
                end
`ifdef BIN_ENC_POPCNT_EN
                chk("m_popcnt", pop_count, model_pc);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        encoder_in = 16'h0;
        out_ready  = 1'b0;

        // reset
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_bin", binary_out, 0);
        chk("rst_last", last, 0);
        chk("rst_ready_hi", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst_ready", in_ready, 1);

        // single bit
        enable     = 1'b1;
        encoder_in = 16'h0002;
        out_ready  = 1'b1;
        step();
        enable = 1'b0;
        chk("t2_valid", out_valid, 1);
        chk("t2_bin", binary_out, 1);
        chk("t2_last", last, 1);
        step();
        chk("t2_valid0", out_valid, 0);
        chk("t2_ready", in_ready, 1);

        // one-hot sweep
        for (int i = 0; i < 16; i++) begin
            enable     = 1'b1;
            encoder_in = 16'(1) << i;
            step();
            enable = 1'b0;
            chk("sweep_bin", binary_out, i);
            chk("sweep_last", last, 1);
            step();
            chk("sweep_done", out_valid, 0);
        end

        // multi-hot with ready held
        enable     = 1'b1;
        encoder_in = 16'h8421;
        step();
        enable = 1'b0;
        chk("mh_0", binary_out, 0);
        chk("mh_0_last", last, 0);
`ifdef BIN_ENC_POPCNT_EN
        chk("mh_pc", pop_count, 4);
`endif
        step();
        chk("mh_5", binary_out, 5);
        step();
        chk("mh_10", binary_out, 10);
        chk("mh_10_last", last, 0);
        step();
        chk("mh_15", binary_out, 15);
        chk("mh_15_last", last, 1);
        step();
        chk("mh_end", out_valid, 0);

        // backpressure and ignored enable
        enable     = 1'b1;
        encoder_in = 16'h0003;
        out_ready  = 1'b0;
        step();
        encoder_in = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_bin", binary_out, 0);
            chk("bp_last", last, 0);
            chk("bp_valid", out_valid, 1);
        end
        enable    = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_bin1", binary_out, 1);
        chk("bp_last1", last, 1);
        step();
        chk("bp_end", out_valid, 0);
        enable     = 1'b1;
        encoder_in = 16'h0;
        step();
        enable = 1'b0;
        chk("zero_drop", out_valid, 0);
        chk("zero_ready", in_ready, 1);

        // reset in the middle of an emission
        enable     = 1'b1;
        encoder_in = 16'hFFFF;
        step();
        enable = 1'b0;
        chk("rm_0", binary_out, 0);
        step();
        step();
        chk("rm_2", binary_out, 2);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rm_valid", out_valid, 0);
        #1;
        chk("rm_ready", in_ready, 1);
        enable     = 1'b1;
        encoder_in = 16'h0010;
        step();
        enable = 1'b0;
        chk("rm_new", binary_out, 4);
        chk("rm_new_last", last, 1);
`ifdef BIN_ENC_POPCNT_EN
        chk("rm_pc", pop_count, 1);
`endif
        step();
        step();

        done = 1'b1;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
